// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: core write (A), multi-cycle result (B), issue, decode query, register-file write.
// Latency: n/a (signal bundle only).
// Backpressure: a_ready/b_ready/iss_ready flow from slave to master.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            iss_valid;
  logic            iss_ready;
  logic [4:0]      iss_rd;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [4:0]      q_rd;
  logic            hazard;
  logic [31:0]     busy_mask;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
           q_rs1, q_rs2, q_rd,
    input  a_ready, b_ready, iss_ready, hazard, busy_mask, wb_en, wb_rd, wb_data
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
           q_rs1, q_rs2, q_rd,
    output a_ready, b_ready, iss_ready, hazard, busy_mask, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between core write-back (A) and a FIFO-buffered multi-cycle unit (B), with a busy scoreboard.
// Latency: A grant -> wb_en next cycle; B push -> wb_en no earlier than two cycles later; B forced after MAX_WAIT A grants.
// Backpressure: a_ready drops only on a forced-B cycle; b_ready is registered FIFO-not-full; iss_ready blocks a busy rd. Optional: WB_BYPASS_EN adds read forwarding.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef WB_BYPASS_EN
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
`endif
  regfile_wb_arbiter_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            b_ready_q;
  logic [WW-1:0]   wait_cnt;
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic [31:0]     clr_vec;
  logic [31:0]     set_vec;
  logic [31:0]     busy_eff;

  logic            fifo_nonempty;
  logic            force_b;
  logic            a_grant;
  logic            b_grant;
  logic            push;
  logic            iss_set;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  logic            wb_en_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Grant selection, FIFO occupancy and scoreboard next-state.
  always_comb begin
    fifo_nonempty = (count != '0);
    force_b       = fifo_nonempty && (wait_cnt == MAX_W);
    a_grant       = !force_b && bus.a_valid;
    // A push into an empty FIFO is not visible here, so it waits a cycle.
    b_grant       = force_b || (!bus.a_valid && fifo_nonempty);
    push          = bus.b_valid && b_ready_q;
    count_next    = count + CW'(push) - CW'(b_grant);
    iss_set       = bus.iss_valid && !busy[bus.iss_rd] && (bus.iss_rd != 5'd0);
    clr_vec       = b_grant ? (32'd1 << head_rd) : 32'd0;
    set_vec       = iss_set ? (32'd1 << bus.iss_rd) : 32'd0;
    // Set is applied after clear so a same-cycle set on the same rd wins.
    busy_next     = ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.b_data;
      fifo_rd[wr_ptr]   <= bus.b_rd;
    end
  end

  // FIFO pointers, occupancy and registered not-full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      b_ready_q <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (b_grant) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      b_ready_q <= (count_next < DEPTH_C);
    end
  end

  // Starvation counter: A grants taken while B waits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (b_grant) begin
      wait_cnt <= '0;
    end else if (a_grant && fifo_nonempty && (wait_cnt != MAX_W)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Scoreboard of registers with a multi-cycle result in flight.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Registered write port; x0 writes complete the handshake but never enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else if (a_grant) begin
      wb_en_q   <= (bus.a_rd != 5'd0);
      wb_rd_q   <= bus.a_rd;
      wb_data_q <= bus.a_data;
    end else if (b_grant) begin
      wb_en_q   <= (head_rd != 5'd0);
      wb_rd_q   <= head_rd;
      wb_data_q <= head_data;
    end else begin
      wb_en_q   <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  logic [31:0] wb_clr_q;

  // Remember which busy bits the write now on wb_* retired.
  always_ff @(posedge clk) begin
    if (reset) wb_clr_q <= '0;
    else       wb_clr_q <= clr_vec & ~set_vec;
  end

  // Bits retired by the write being forwarded this cycle never stall decode.
  assign busy_eff = busy & ~wb_clr_q;
  assign rs1_data = (wb_en_q && (wb_rd_q == bus.q_rs1)) ? wb_data_q : rf_rs1_data;
  assign rs2_data = (wb_en_q && (wb_rd_q == bus.q_rs2)) ? wb_data_q : rf_rs2_data;
`else
  assign busy_eff = busy;
`endif

  assign bus.a_ready   = !force_b;
  assign bus.b_ready   = b_ready_q;
  assign bus.iss_ready = !busy[bus.iss_rd];
  assign bus.hazard    = busy_eff[bus.q_rs1] | busy_eff[bus.q_rs2] | busy_eff[bus.q_rd];
  assign bus.busy_mask = busy;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule
